// File: rtl/trap_controller_pkg.sv
// Shared trap definitions for the trap sequencer and the exception detector.
// Contents: trap_status codes, 4-bit mcause values, CSR addresses, FSM state
// type, and the mtval source selector.
package trap_controller_pkg;

   localparam logic [1:0] TRAP_EBREAK     = 2'b00;
   localparam logic [1:0] TRAP_ECALL      = 2'b01;
   localparam logic [1:0] TRAP_MISALIGNED = 2'b10;
   localparam logic [1:0] TRAP_ILLEGAL    = 2'b11;

   localparam logic [3:0] MCAUSE_EBREAK     = 4'd3;
   localparam logic [3:0] MCAUSE_ECALL      = 4'd11;
   localparam logic [3:0] MCAUSE_MISALIGNED = 4'd0;
   localparam logic [3:0] MCAUSE_ILLEGAL    = 4'd2;

   localparam logic [11:0] CSR_MEPC   = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;
   localparam logic [11:0] CSR_MTVAL  = 12'h343;
   localparam logic [11:0] CSR_MTVEC  = 12'h305;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_MEPC,
      ST_WR_MCAUSE,
      ST_WR_MTVAL,
      ST_RD_MTVEC,
      ST_RD_MEPC,
      ST_REDIRECT
   } state_t;

   typedef enum logic [1:0] {
      MTVAL_ZERO,
      MTVAL_PC,
      MTVAL_NEXT_PC
   } mtval_sel_t;

endpackage

// File: rtl/trap_controller_cause_encoder.sv
// trap_cause_encoder: combinational map from trap_status to the mcause code
// and the source of the mtval value.
//   i_trap_status : trap cause code from the exception detector
//   o_mcause      : 4-bit exception code (interrupt bit is always 0)
//   o_mtval_sel   : zero, faulting pc, or computed target (next_pc)
module trap_cause_encoder
   import trap_controller_pkg::*;
(
   input  logic [1:0] i_trap_status,
   output logic [3:0] o_mcause,
   output mtval_sel_t o_mtval_sel
);

   always_comb begin
      o_mcause    = MCAUSE_ILLEGAL;
      o_mtval_sel = MTVAL_ZERO;
      case (i_trap_status)
         TRAP_EBREAK: begin
            o_mcause    = MCAUSE_EBREAK;
            o_mtval_sel = MTVAL_PC;
         end
         TRAP_ECALL: begin
            o_mcause    = MCAUSE_ECALL;
            o_mtval_sel = MTVAL_ZERO;
         end
         TRAP_MISALIGNED: begin
            o_mcause    = MCAUSE_MISALIGNED;
            o_mtval_sel = MTVAL_NEXT_PC;
         end
         default: begin
            o_mcause    = MCAUSE_ILLEGAL;
            o_mtval_sel = MTVAL_ZERO;
         end
      endcase
   end

endmodule

// File: rtl/trap_controller.sv
// trap_controller: serialises trap entry (mepc/mcause/mtval writes, mtvec read)
// and MRET (mepc read) over single CSR read/write ports, then pulses a redirect.
//   clk, reset        : core clock; asynchronous active-high reset
//   trapped/trap_status/pc/next_pc : trap request, sampled only in IDLE
//   mret              : decoded MRET, sampled only in IDLE (trap wins)
//   csr_read_data     : combinational CSR read data
//   pc_stall          : hold PC and IF/ID, request cycle through REDIRECT
//   csr_write_*       : CSR write port, zero outside the write states
//   csr_read_address  : CSR read address, zero outside the read states
//   trap_target       : registered redirect address (word aligned)
//   trap_redirect     : one-cycle pulse, PC controller loads trap_target
module trap_controller
   import trap_controller_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            trapped,
   input  logic [1:0]      trap_status,
   input  logic            mret,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] next_pc,
   input  logic [XLEN-1:0] csr_read_data,
   output logic            pc_stall,
   output logic            csr_write_enable,
   output logic [11:0]     csr_write_address,
   output logic [XLEN-1:0] csr_write_data,
   output logic [11:0]     csr_read_address,
   output logic [XLEN-1:0] trap_target,
   output logic            trap_redirect
);

   state_t          r_state;
   state_t          w_next_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_next_pc;
   logic [1:0]      r_status;
   logic [XLEN-1:0] r_trap_target;
   logic [3:0]      w_mcause;
   mtval_sel_t      w_mtval_sel;
   logic [XLEN-1:0] w_mtval;

   trap_cause_encoder u_cause (
      .i_trap_status (r_status),
      .o_mcause      (w_mcause),
      .o_mtval_sel   (w_mtval_sel)
   );

   always_comb begin
      case (w_mtval_sel)
         MTVAL_PC:      w_mtval = r_pc;
         MTVAL_NEXT_PC: w_mtval = r_next_pc;
         default:       w_mtval = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc          <= '0;
         r_next_pc     <= '0;
         r_status      <= '0;
         r_trap_target <= '0;
      end else begin
         if (r_state == ST_IDLE && trapped) begin
            r_pc      <= pc;
            r_next_pc <= next_pc;
            r_status  <= trap_status;
         end
         // Direct mode only: the low two bits (mode field / alignment) are dropped.
         if (r_state == ST_RD_MTVEC || r_state == ST_RD_MEPC) begin
            r_trap_target <= csr_read_data & {{(XLEN-2){1'b1}}, 2'b00};
         end
      end
   end

   always_comb begin
      w_next_state      = r_state;
      pc_stall          = 1'b0;
      csr_write_enable  = 1'b0;
      csr_write_address = '0;
      csr_write_data    = '0;
      csr_read_address  = '0;
      trap_redirect     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Gated by reset so every output is 0 while reset is held.
            pc_stall = ~reset & (trapped | mret);
            if (trapped) begin
               w_next_state = ST_WR_MEPC;
            end else if (mret) begin
               w_next_state = ST_RD_MEPC;
            end
         end
         ST_WR_MEPC: begin
            pc_stall          = 1'b1;
            csr_write_enable  = 1'b1;
            csr_write_address = CSR_MEPC;
            csr_write_data    = r_pc;
            w_next_state      = ST_WR_MCAUSE;
         end
         ST_WR_MCAUSE: begin
            pc_stall          = 1'b1;
            csr_write_enable  = 1'b1;
            csr_write_address = CSR_MCAUSE;
            csr_write_data    = {{(XLEN-4){1'b0}}, w_mcause};
            w_next_state      = ST_WR_MTVAL;
         end
         ST_WR_MTVAL: begin
            pc_stall          = 1'b1;
            csr_write_enable  = 1'b1;
            csr_write_address = CSR_MTVAL;
            csr_write_data    = w_mtval;
            w_next_state      = ST_RD_MTVEC;
         end
         ST_RD_MTVEC: begin
            pc_stall         = 1'b1;
            csr_read_address = CSR_MTVEC;
            w_next_state     = ST_REDIRECT;
         end
         ST_RD_MEPC: begin
            pc_stall         = 1'b1;
            csr_read_address = CSR_MEPC;
            w_next_state     = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            pc_stall      = 1'b1;
            trap_redirect = 1'b1;
            w_next_state  = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   assign trap_target = r_trap_target;

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: a CSR-file model answers reads and logs writes;
// a step-list reference model predicts all outputs every cycle.
module tb_trap_controller;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            trapped;
   logic [1:0]      trap_status;
   logic            mret;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] next_pc;
   logic [XLEN-1:0] csr_read_data;
   logic            pc_stall;
   logic            csr_write_enable;
   logic [11:0]     csr_write_address;
   logic [XLEN-1:0] csr_write_data;
   logic [11:0]     csr_read_address;
   logic [XLEN-1:0] trap_target;
   logic            trap_redirect;

   always #5 clk = ~clk;

   trap_controller #(.XLEN(XLEN)) dut (
      .clk               (clk),
      .reset             (reset),
      .trapped           (trapped),
      .trap_status       (trap_status),
      .mret              (mret),
      .pc                (pc),
      .next_pc           (next_pc),
      .csr_read_data     (csr_read_data),
      .pc_stall          (pc_stall),
      .csr_write_enable  (csr_write_enable),
      .csr_write_address (csr_write_address),
      .csr_write_data    (csr_write_data),
      .csr_read_address  (csr_read_address),
      .trap_target       (trap_target),
      .trap_redirect     (trap_redirect)
   );

   // ---------------- CSR file environment ----------------
   logic [31:0] c_mepc = '0, c_mcause = '0, c_mtval = '0, c_mtvec = '0;
   logic        pre_en;
   logic [11:0] pre_addr;
   logic [31:0] pre_data;

   typedef struct packed {
      logic [11:0] a;
      logic [31:0] d;
   } wr_t;
   wr_t wlog[$];
   int  cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pre_en) begin
         case (pre_addr)
            12'h305: c_mtvec <= pre_data;
            12'h341: c_mepc  <= pre_data;
            default: ;
         endcase
      end
      if (csr_write_enable) begin
         wlog.push_back({csr_write_address, csr_write_data});
         case (csr_write_address)
            12'h341: c_mepc   <= csr_write_data;
            12'h342: c_mcause <= csr_write_data;
            12'h343: c_mtval  <= csr_write_data;
            12'h305: c_mtvec  <= csr_write_data;
            default: ;
         endcase
      end
   end

   always_comb begin
      csr_read_data = 32'hDEAD_BEEF;
      case (csr_read_address)
         12'h305: csr_read_data = c_mtvec;
         12'h341: csr_read_data = c_mepc;
         12'h342: csr_read_data = c_mcause;
         12'h343: csr_read_data = c_mtval;
         default: ;
      endcase
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic        we;
      logic [11:0] wa;
      logic [31:0] wd;
      logic [11:0] ra;
      logic        redir;
      logic        ld_mtvec;
      logic        ld_mepc;
   } step_t;

   step_t       mq[$];
   logic [31:0] m_target = '0;
   logic [31:0] m_mepc   = '0;
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_redir = 0;
   int          redir_cyc = -1;
   int          req_cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic step_t mk(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                                input logic [11:0] ra, input logic redir,
                                input logic lt, input logic le);
      step_t s;
      s.we = we; s.wa = wa; s.wd = wd; s.ra = ra;
      s.redir = redir; s.ld_mtvec = lt; s.ld_mepc = le;
      return s;
   endfunction

   // A trap request becomes a fixed list of per-cycle bus actions.
   task automatic push_trap(input logic [1:0] st, input logic [31:0] p, input logic [31:0] np);
      logic [31:0] cause, tval;
      case (st)
         2'd0:    begin cause = 3;  tval = p;  end
         2'd1:    begin cause = 11; tval = 0;  end
         2'd2:    begin cause = 0;  tval = np; end
         default: begin cause = 2;  tval = 0;  end
      endcase
      mq.push_back(mk(1'b1, 12'h341, p,     12'h000, 1'b0, 1'b0, 1'b0));
      mq.push_back(mk(1'b1, 12'h342, cause, 12'h000, 1'b0, 1'b0, 1'b0));
      mq.push_back(mk(1'b1, 12'h343, tval,  12'h000, 1'b0, 1'b0, 1'b0));
      mq.push_back(mk(1'b0, 12'h000, 0,     12'h305, 1'b0, 1'b1, 1'b0));
      mq.push_back(mk(1'b0, 12'h000, 0,     12'h000, 1'b1, 1'b0, 1'b0));
   endtask

   task automatic push_mret();
      mq.push_back(mk(1'b0, 12'h000, 0, 12'h341, 1'b0, 1'b0, 1'b1));
      mq.push_back(mk(1'b0, 12'h000, 0, 12'h000, 1'b1, 1'b0, 1'b0));
   endtask

   always @(negedge clk) begin : cmp
      step_t s;
      logic  e_stall;
      logic  idle;
      s     = mk(1'b0, 12'h000, 0, 12'h000, 1'b0, 1'b0, 1'b0);
      idle  = 1'b0;
      if (reset) begin
         mq.delete();
         m_target = '0;
         e_stall  = 1'b0;
      end else if (mq.size() > 0) begin
         s       = mq.pop_front();
         e_stall = 1'b1;
      end else begin
         idle    = 1'b1;
         e_stall = trapped | mret;
      end
      chk("pc_stall",          32'(pc_stall),          32'(e_stall));
      chk("csr_write_enable",  32'(csr_write_enable),  32'(s.we));
      chk("csr_write_address", 32'(csr_write_address), 32'(s.wa));
      chk("csr_write_data",    csr_write_data,         s.wd);
      chk("csr_read_address",  32'(csr_read_address),  32'(s.ra));
      chk("trap_redirect",     32'(trap_redirect),     32'(s.redir));
      chk("trap_target",       trap_target,            m_target);
      if (trap_redirect) begin
         n_redir++;
         redir_cyc = cyc;
      end
      if (!reset) begin
         if (s.we && s.wa == 12'h341) m_mepc = s.wd;
         if (s.ld_mtvec) m_target = {c_mtvec[31:2], 2'b00};
         if (s.ld_mepc)  m_target = {m_mepc[31:2], 2'b00};
         if (idle) begin
            if (trapped)   push_trap(trap_status, pc, next_pc);
            else if (mret) push_mret();
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic preload(input logic [11:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      if (a == 12'h341) m_mepc = d;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   // Drives a one-cycle request; returns one cycle after the request cycle.
   task automatic fire(input logic t, input logic m, input logic [1:0] st,
                       input logic [31:0] p, input logic [31:0] np);
      @(posedge clk); #1;
      trapped = t; mret = m; trap_status = st; pc = p; next_pc = np;
      req_cyc = cyc;
      @(posedge clk); #1;
      trapped = 1'b0; mret = 1'b0;
   endtask

   function automatic logic [31:0] wl_a(input int i);
      return (wlog.size() > i) ? 32'(wlog[i].a) : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] wl_d(input int i);
      return (wlog.size() > i) ? wlog[i].d : 32'hFFFF_FFFF;
   endfunction

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n_r0;
      reset = 1'b1; trapped = 1'b0; mret = 1'b0; trap_status = '0;
      pc = '0; next_pc = '0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_trap_target", trap_target, 32'h0);
      chk("reset_pc_stall", 32'(pc_stall), 32'h0);
      reset = 1'b0;

      // ECALL
      preload(12'h305, 32'h200);
      wlog.delete();
      fire(1'b1, 1'b0, 2'b01, 32'h100, 32'h104);
      repeat (5) @(posedge clk);
      #1;
      chk("ecall_nwrites", 32'(wlog.size()), 32'd3);
      chk("ecall_w0_addr", wl_a(0), 32'h341);
      chk("ecall_w0_data", wl_d(0), 32'h100);
      chk("ecall_w1_addr", wl_a(1), 32'h342);
      chk("ecall_w1_data", wl_d(1), 32'hB);
      chk("ecall_w2_addr", wl_a(2), 32'h343);
      chk("ecall_w2_data", wl_d(2), 32'h0);
      chk("ecall_redirect_cycle", 32'(redir_cyc - req_cyc), 32'd5);
      chk("ecall_target", trap_target, 32'h200);
      chk("ecall_stall_after", 32'(pc_stall), 32'h0);

      // Misaligned target
      preload(12'h305, 32'h303);
      wlog.delete();
      fire(1'b1, 1'b0, 2'b10, 32'h80, 32'hF1);
      repeat (5) @(posedge clk);
      #1;
      chk("misal_mcause", wl_d(1), 32'h0);
      chk("misal_mtval", wl_d(2), 32'hF1);
      chk("misal_target", trap_target, 32'h300);

      // MRET
      preload(12'h341, 32'h104);
      wlog.delete();
      fire(1'b0, 1'b1, 2'b00, 32'h500, 32'h504);
      repeat (2) @(posedge clk);
      #1;
      chk("mret_nwrites", 32'(wlog.size()), 32'd0);
      chk("mret_redirect_cycle", 32'(redir_cyc - req_cyc), 32'd2);
      chk("mret_target", trap_target, 32'h104);

      // Simultaneous EBREAK + mret, then a stray trap pulse in WR_MCAUSE
      wlog.delete();
      @(posedge clk); #1;
      trapped = 1'b1; mret = 1'b1; trap_status = 2'b00; pc = 32'h2A4; next_pc = 32'h999;
      req_cyc = cyc;
      @(posedge clk); #1;
      trapped = 1'b0; mret = 1'b1;
      @(posedge clk); #1;
      trapped = 1'b1; mret = 1'b0; trap_status = 2'b11; pc = 32'h777;
      @(posedge clk); #1;
      trapped = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("simul_nwrites", 32'(wlog.size()), 32'd3);
      chk("simul_mepc", wl_d(0), 32'h2A4);
      chk("simul_mcause", wl_d(1), 32'h3);
      chk("simul_mtval", wl_d(2), 32'h2A4);
      chk("simul_redirect_cycle", 32'(redir_cyc - req_cyc), 32'd5);

      // Reset asserted during WR_MCAUSE
      wlog.delete();
      n_r0 = n_redir;
      @(posedge clk); #1;
      trapped = 1'b1; trap_status = 2'b01; pc = 32'h3C0;
      @(posedge clk); #1;
      trapped = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("rst_mid_stall", 32'(pc_stall), 32'h0);
      chk("rst_mid_we", 32'(csr_write_enable), 32'h0);
      chk("rst_mid_waddr", 32'(csr_write_address), 32'h0);
      chk("rst_mid_target", trap_target, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("rst_mid_nwrites", 32'(wlog.size()), 32'd1);
      chk("rst_mid_mcause_kept", c_mcause, 32'h3);
      chk("rst_mid_no_redirect", 32'(n_redir - n_r0), 32'd0);
      wlog.delete();
      fire(1'b1, 1'b0, 2'b01, 32'h400, 32'h404);
      repeat (5) @(posedge clk);
      #1;
      chk("post_rst_nwrites", 32'(wlog.size()), 32'd3);
      chk("post_rst_redirect_cycle", 32'(redir_cyc - req_cyc), 32'd5);
      chk("post_rst_target", trap_target, 32'h300);

      // Randomised traffic
      repeat (400) begin
         @(posedge clk); #1;
         trapped     = ($urandom_range(0, 3) == 0);
         mret        = ($urandom_range(0, 3) == 0);
         trap_status = 2'($urandom_range(0, 3));
         pc          = $urandom;
         next_pc     = $urandom;
         pre_en      = ($urandom_range(0, 7) == 0);
         pre_addr    = 12'h305;
         pre_data    = $urandom;
      end
      @(posedge clk); #1;
      trapped = 1'b0; mret = 1'b0; pre_en = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
